imem_fetch_ctrl: RTL

Instruction-fetch controller sitting between the core's decode stage and the synchronous-read instruction memory (`imem`, 1-cycle registered read, word-addressed). Generates the word address stream, tracks the in-flight read, and buffers returned words in a 2-entry FIFO behind a valid/ready handshake. It also handles branch/jump redirects, flushing stale data, and wraps the PC at the top of the memory.

---
 rtl/imem_fetch_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch controller with 2-entry return FIFO; optional FETCH_STALL_CNT_EN adds stall_cnt
module imem_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;
  logic [1:0]            count_q;
  logic                  rd_ptr_q, wr_ptr_q;
  logic [ADDR_WIDTH-1:0] fifo_pc_q    [2];
  logic [DATA_WIDTH-1:0] fifo_instr_q [2];

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            occ;

  // The redirect target goes straight to the memory so it is read in the redirect cycle itself.
  assign imem_addr = redirect_valid ? redirect_pc : pc_q;
  assign out_valid = (count_q != 2'd0) & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  // A word returning during a redirect belongs to the abandoned path and is dropped.
  assign push      = inflight_q & ~redirect_valid;
  // Occupancy after this edge counts the read in flight, so issue never overruns the FIFO.
  assign occ       = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = redirect_valid | (fetch_en & (occ < 3'd2));
  assign out_instr = fifo_instr_q[rd_ptr_q];
  assign out_pc    = fifo_pc_q[rd_ptr_q];

  // Address generator and in-flight read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (issue) begin
      pc_q          <= imem_addr + 1'b1;
      inflight_q    <= 1'b1;
      inflight_pc_q <= imem_addr;
    end else begin
      inflight_q    <= 1'b0;
    end
  end

  // Two-entry return FIFO; a redirect empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
        fifo_instr_q[wr_ptr_q] <= imem_dout;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Fetch state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch state: idle with nothing pending, running, or held by a full pipeline.
  always_comb begin
    state_d = state_q;
    if (!fetch_en && !redirect_valid && !inflight_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (fetch_en || redirect_valid) state_d = ST_RUN;
        ST_RUN:  if (!issue)                     state_d = ST_HOLD;
        ST_HOLD: if (pop || redirect_valid)      state_d = ST_RUN;
        default:                                 state_d = ST_IDLE;
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  // Cycles where the core wants instructions but none is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (fetch_en && !out_valid && !redirect_valid) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A full FIFO may only accept a word when the head leaves in the same cycle.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && (count_q == 2'd2)));
`endif

endmodule
